// File: rtl/simon_mixed_round_core.sv
// SIMON32/64 encryption datapath: ROUNDS_PER_CYCLE rounds and key-schedule steps
// are unrolled per clock, so a block takes 32/ROUNDS_PER_CYCLE iterations.
module simon_mixed_round_core #(
  parameter int ROUNDS_PER_CYCLE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_load,
  input  logic [31:0] core_plaintext,
  input  logic [63:0] core_key,
  output logic        core_busy,
  output logic        core_ct_valid,
  output logic [31:0] core_ciphertext,
  output logic [4:0]  core_round
);

  localparam int         ITERS      = 32 / ROUNDS_PER_CYCLE;
  localparam logic [4:0] LAST_ITER  = 5'(ITERS - 1);
  localparam logic [4:0] ROUND_STEP = 5'(ROUNDS_PER_CYCLE % 32);
  // z0 bits 0..31, bit 0 is the MSB of this literal
  localparam logic [31:0] Z0_HEAD   = 32'b11111010001001010110000111001101;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [63:0] key_q, key_d;
  logic [4:0]  round_q, round_d;
  logic [4:0]  iter_q, iter_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [31:0] ct_q, ct_d;

  logic [15:0] xa, ya, xn, tmp, knew;
  logic [63:0] kw;
  logic [4:0]  rnd;

  function automatic logic [15:0] simon_f(input logic [15:0] v);
    return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
  endfunction

  function automatic logic [15:0] ror3(input logic [15:0] v);
    return {v[2:0], v[15:3]};
  endfunction

  function automatic logic [15:0] ror1(input logic [15:0] v);
    return {v[0], v[15:1]};
  endfunction

  // Unrolled rounds; kw is the sliding key window with k_i in the low word.
  always_comb begin
    xa   = x_q;
    ya   = y_q;
    kw   = key_q;
    rnd  = round_q;
    xn   = '0;
    tmp  = '0;
    knew = '0;
    for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
      tmp  = ror3(kw[63:48]) ^ kw[31:16];
      tmp  = tmp ^ ror1(tmp);
      knew = ~kw[15:0] ^ tmp ^ {15'd0, Z0_HEAD[5'd31 - rnd]} ^ 16'h0003;
      xn   = ya ^ simon_f(xa) ^ kw[15:0];
      ya   = xa;
      xa   = xn;
      kw   = {knew, kw[63:16]};
      rnd  = rnd + 5'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    key_d   = key_q;
    round_d = round_q;
    iter_d  = iter_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    ct_d    = ct_q;
    // A load always wins, including over the final iteration of a running block.
    if (core_load) begin
      x_d     = core_plaintext[31:16];
      y_d     = core_plaintext[15:0];
      key_d   = core_key;
      round_d = '0;
      iter_d  = '0;
      busy_d  = 1'b1;
      state_d = RUN;
    end else begin
      unique case (state_q)
        IDLE: ;
        RUN: begin
          x_d     = xa;
          y_d     = ya;
          key_d   = kw;
          round_d = round_q + ROUND_STEP;
          if (iter_q == LAST_ITER) begin
            ct_d    = {xa, ya};
            valid_d = 1'b1;
            busy_d  = 1'b0;
            iter_d  = '0;
            state_d = IDLE;
          end else begin
            iter_d  = iter_q + 5'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      key_q   <= '0;
      round_q <= '0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      key_q   <= key_d;
      round_q <= round_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      ct_q    <= ct_d;
    end
  end

  assign core_busy       = busy_q;
  assign core_ct_valid   = valid_q;
  assign core_ciphertext = ct_q;
  assign core_round      = round_q;

endmodule

// File: tb/tb_simon_mixed_round_core.sv
// Scoreboard bench for simon_mixed_round_core: the driver queues expected
// ciphertext and valid cycle, a negedge monitor pops on every core_ct_valid.
module tb_simon_mixed_round_core;

  localparam int ITERS = 4;
  localparam logic [63:0] KAT_KEY = 64'h1918111009080100;
  localparam logic [31:0] KAT_PT  = 32'h65656877;
  localparam logic [31:0] KAT_CT  = 32'hc69be9bb;
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_load;
  logic        sw_load;
  logic [31:0] core_plaintext;
  logic [63:0] core_key;
  logic        core_busy;
  logic        core_ct_valid;
  logic [31:0] core_ciphertext;
  logic [4:0]  core_round;

  logic [3:0]  sw_busy;
  logic [3:0]  sw_valid;
  logic [31:0] sw_ct [4];
  logic [4:0]  sw_round [4];

  always #5 clk = ~clk;

  simon_mixed_round_core #(.ROUNDS_PER_CYCLE(8)) u_dut (
    .clk(clk), .rst(rst), .core_load(core_load),
    .core_plaintext(core_plaintext), .core_key(core_key),
    .core_busy(core_busy), .core_ct_valid(core_ct_valid),
    .core_ciphertext(core_ciphertext), .core_round(core_round)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sweep
      simon_mixed_round_core #(
        .ROUNDS_PER_CYCLE(gi == 0 ? 1 : gi == 1 ? 2 : gi == 2 ? 16 : 32)
      ) u_sw (
        .clk(clk), .rst(rst), .core_load(sw_load),
        .core_plaintext(core_plaintext), .core_key(core_key),
        .core_busy(sw_busy[gi]), .core_ct_valid(sw_valid[gi]),
        .core_ciphertext(sw_ct[gi]), .core_round(sw_round[gi])
      );
    end
  endgenerate

  typedef struct {
    logic [31:0] ct;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pushes = 0;
  int   valids = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] rol(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  // Reference: full key expansion first, then 32 rounds.
  function automatic logic [31:0] simon_ref(input logic [63:0] key, input logic [31:0] pt);
    logic [15:0] k [32];
    logic [15:0] x, y, t;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 0; i < 28; i++) begin
      t = rol(k[i+3], 13) ^ k[i+1];
      t = t ^ rol(t, 15);
      k[i+4] = ~k[i] ^ t ^ {15'd0, Z0[61-i]} ^ 16'h0003;
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (core_ct_valid === 1'b1) begin
      valids++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid with ct %0h at cycle %0d, expected none",
                 core_ciphertext, cyc);
      end else begin
        e = exp_q.pop_front();
        $display("txn ct=%h at cycle %0d (expected %h at %0d)", core_ciphertext, cyc, e.ct, e.at);
        chk("ciphertext", core_ciphertext, e.ct);
        chk("latency", cyc, e.at);
      end
    end
  end

  // Called at a negedge; drives a one-cycle load and returns at the next negedge.
  task automatic do_load(input logic [63:0] k, input logic [31:0] p,
                         input logic push, input logic [31:0] ct);
    exp_t e;
    core_key       = k;
    core_plaintext = p;
    core_load      = 1'b1;
    if (push) begin
      e.ct = ct;
      e.at = cyc + 1 + ITERS;
      exp_q.push_back(e);
      pushes++;
    end
    @(negedge clk);
    core_load = 1'b0;
  endtask

  task automatic wait_drain(input int extra);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (extra) @(negedge clk);
  endtask

  initial begin
    logic [63:0] rk;
    logic [31:0] rp;
    logic [31:0] last_ct;
    logic [63:0] key_a, key_b;
    logic [31:0] pt_a, pt_b;
    int          lat [4];
    int          npulse [4];

    rst = 1'b1;
    core_load = 1'b0;
    sw_load = 1'b0;
    core_key = '0;
    core_plaintext = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", core_busy, 0);
    chk("reset_valid", core_ct_valid, 0);
    chk("reset_ct", core_ciphertext, 0);
    chk("reset_round", core_round, 0);
    rst = 1'b0;
    @(negedge clk);

    // Known answer, with busy/round trace through the run
    do_load(KAT_KEY, KAT_PT, 1'b1, KAT_CT);
    for (int i = 0; i < ITERS; i++) begin
      chk("kat_busy", core_busy, 1);
      chk("kat_round", core_round, 64'(i * 8));
      @(negedge clk);
    end
    chk("kat_busy_done", core_busy, 0);

    // Back-to-back: load in the cycle after valid; first result must hold
    @(negedge clk);
    do_load(KAT_KEY, 32'h0, 1'b1, simon_ref(KAT_KEY, 32'h0));
    for (int i = 0; i < 3; i++) begin
      chk("b2b_hold", core_ciphertext, KAT_CT);
      @(negedge clk);
    end
    wait_drain(4);

    // Abort: second load two cycles after the first
    key_a = 64'h0123456789abcdef; pt_a = 32'hdeadbeef;
    key_b = 64'hfedcba9876543210; pt_b = 32'h13579bdf;
    do_load(key_a, pt_a, 1'b0, '0);
    @(negedge clk);
    do_load(key_b, pt_b, 1'b1, simon_ref(key_b, pt_b));
    wait_drain(6);
    last_ct = simon_ref(key_b, pt_b);

    // Load coinciding with the final iteration: new load wins, old result dropped
    do_load(key_b, pt_a, 1'b0, '0);
    repeat (3) @(negedge clk);
    do_load(key_a, pt_b, 1'b1, simon_ref(key_a, pt_b));
    chk("collide_hold", core_ciphertext, last_ct);
    chk("collide_busy", core_busy, 1);
    wait_drain(6);

    // Reset in iteration 2, with a load during reset that must be ignored
    do_load(key_a, pt_a, 1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    core_load = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    core_load = 1'b0;
    chk("midrst_busy", core_busy, 0);
    chk("midrst_valid", core_ct_valid, 0);
    chk("midrst_ct", core_ciphertext, 0);
    chk("midrst_round", core_round, 0);
    repeat (6) @(negedge clk);
    chk("midrst_idle", core_busy, 0);
    do_load(KAT_KEY, KAT_PT, 1'b1, KAT_CT);
    wait_drain(2);

    // Random vectors against the reference model
    for (int n = 0; n < 200; n++) begin
      rk = {$urandom, $urandom};
      rp = $urandom;
      do_load(rk, rp, 1'b1, simon_ref(rk, rp));
      wait_drain($urandom_range(0, 2));
    end
    wait_drain(4);

    // Parameter sweep on the extra instances
    for (int j = 0; j < 4; j++) begin
      lat[j] = -1;
      npulse[j] = 0;
    end
    core_key = KAT_KEY;
    core_plaintext = KAT_PT;
    sw_load = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      sw_load = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (sw_valid[j] === 1'b1) begin
          npulse[j]++;
          if (lat[j] < 0) lat[j] = c - 1;
          chk("sweep_ct", sw_ct[j], KAT_CT);
        end
      end
    end
    for (int j = 0; j < 4; j++) begin
      $display("txn sweep instance %0d latency %0d", j, lat[j]);
      chk("sweep_latency", lat[j], 64'(j == 0 ? 32 : j == 1 ? 16 : j == 2 ? 2 : 1));
      chk("sweep_pulses", npulse[j], 1);
      chk("sweep_idle", {sw_busy[j], sw_round[j]}, 0);
    end

    chk("valid_count", valids, pushes);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
